srl_tap_bank: RTL and testbench

- Parametrised shift-register bank: WIDTH independent 1-bit channels, each DEPTH stages deep, sharing one shift enable and one dynamic tap address.
- Successor to the fixed-length enabled shift register used in the synth_xilinx_srl architecture tests. Adds a variable tap (SRLC-style addressable read), a cascade output, an optional output register, and a fill tracker that flags when the tapped data is meaningful.
- Written so the shift array maps to SRL primitives: the array itself has no reset.

---
 rtl/srl_tap_bank.sv | 81 ++++++++
 tb/tb_srl_tap_bank.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/srl_tap_bank.sv
// Bank of WIDTH addressable shift registers sharing one enable and one tap address.
// The shift array carries no reset so it can map onto SRL primitives; fill/valid live in flops.
module srl_tap_bank #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH),
  parameter int OUTREG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             e,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic [AW:0]      fill
);

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [DEPTH-1:0] sr [WIDTH];
  logic [AW-1:0]    ea;
  logic [WIDTH-1:0] tap;
  logic             tap_valid;

  // Bit 0 is the newest stage, bit DEPTH-1 the oldest.
  always_ff @(posedge clk) begin
    if (e) begin
      for (int ch = 0; ch < WIDTH; ch++) begin
        sr[ch] <= {sr[ch][DEPTH-2:0], a[ch]};
      end
    end
  end

  always_comb begin
    ea        = ({1'b0, addr} >= DEPTH_L) ? LAST : addr;
    tap_valid = (fill > {1'b0, ea});
    tap       = '0;
    q         = '0;
    for (int ch = 0; ch < WIDTH; ch++) begin
      tap[ch] = sr[ch][ea];
      q[ch]   = sr[ch][DEPTH-1];
    end
  end

  // A stage is meaningful once at least ea+1 shifts have landed since reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill <= '0;
    end else if (e && (fill != DEPTH_L)) begin
      fill <= fill + (AW+1)'(1);
    end
  end

  generate
    if (OUTREG != 0) begin : g_outreg
      logic [WIDTH-1:0] z_r;
      logic             valid_r;

      // Samples the pre-shift array on every edge, regardless of e.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          z_r     <= '0;
          valid_r <= 1'b0;
        end else begin
          z_r     <= tap;
          valid_r <= tap_valid;
        end
      end

      assign z     = z_r;
      assign valid = valid_r;
    end else begin : g_comb
      assign z     = tap;
      assign valid = tap_valid;
    end
  endgenerate

endmodule

// File: tb/tb_srl_tap_bank.sv
// Directed bench for srl_tap_bank: three instances (8-deep comb, 8-deep registered,
// 6-deep comb) share stimulus; a small shift model supplies expectations for the random phase.
module tb_srl_tap_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0;
  logic       e = 1'b0;
  logic [2:0] addr = '0;

  logic [3:0] z0, q0, z1, q1, z2, q2;
  logic       valid0, valid1, valid2;
  logic [3:0] fill0, fill1, fill2;

  int checks = 0;
  int errors = 0;

  logic [7:0] m8 [4];
  logic [5:0] m6 [4];
  int         f8, f6;
  logic [3:0] zr1;
  logic       vr1;

  always #5 clk = ~clk;

  srl_tap_bank #(.WIDTH(4), .DEPTH(8), .AW(3), .OUTREG(0)) u0 (
    .clk(clk), .rst(rst), .a(a), .e(e), .addr(addr),
    .z(z0), .q(q0), .valid(valid0), .fill(fill0));

  srl_tap_bank #(.WIDTH(4), .DEPTH(8), .AW(3), .OUTREG(1)) u1 (
    .clk(clk), .rst(rst), .a(a), .e(e), .addr(addr),
    .z(z1), .q(q1), .valid(valid1), .fill(fill1));

  srl_tap_bank #(.WIDTH(4), .DEPTH(6), .AW(3), .OUTREG(0)) u2 (
    .clk(clk), .rst(rst), .a(a), .e(e), .addr(addr),
    .z(z2), .q(q2), .valid(valid2), .fill(fill2));

  function automatic logic [3:0] tap8(input logic [2:0] ad);
    logic [3:0] r;
    for (int ch = 0; ch < 4; ch++) r[ch] = m8[ch][ad];
    return r;
  endfunction

  function automatic logic [3:0] tap6(input logic [2:0] ad);
    logic [3:0] r;
    int ea;
    ea = (ad >= 3'd6) ? 5 : int'(ad);
    for (int ch = 0; ch < 4; ch++) r[ch] = m6[ch][ea];
    return r;
  endfunction

  task automatic model_reset();
    f8 = 0; f6 = 0; zr1 = '0; vr1 = 1'b0;
  endtask

  // One clock edge with the inputs currently applied; model follows the edge.
  task automatic tick();
    logic [3:0] nz;
    logic       nv;
    nz = tap8(addr);
    nv = (int'(addr) < f8);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      zr1 = nz;
      vr1 = nv;
      if (e) begin
        for (int ch = 0; ch < 4; ch++) begin
          m8[ch] = {m8[ch][6:0], a[ch]};
          m6[ch] = {m6[ch][4:0], a[ch]};
        end
        if (f8 < 8) f8++;
        if (f6 < 6) f6++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #2;
    checks++; if (fill0 !== 4'd0) begin errors++; $display("FAIL reset_fill0 got %0d exp 0", fill0); end
    checks++; if (fill2 !== 4'd0) begin errors++; $display("FAIL reset_fill2 got %0d exp 0", fill2); end
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid0 got %b exp 0", valid0); end
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid1 got %b exp 0", valid1); end
    checks++; if (z1 !== 4'h0) begin errors++; $display("FAIL reset_z1 got %h exp 0", z1); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      a = 4'(i + 1); e = 1'b1; addr = 3'd0;
      tick();
      #2;
      checks++; if (fill0 !== 4'(i + 1)) begin errors++; $display("FAIL fill_count step %0d got %0d exp %0d", i, fill0, i + 1); end
      checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL fill_valid step %0d got %b exp 1", i, valid0); end
      checks++; if (z0 !== 4'(i + 1)) begin errors++; $display("FAIL fill_z step %0d got %h exp %h", i, z0, 4'(i + 1)); end
      checks++; if (fill2 !== 4'((i < 6) ? i + 1 : 6)) begin errors++; $display("FAIL fill_sat6 step %0d got %0d", i, fill2); end
      checks++; if (valid1 !== (i > 0)) begin errors++; $display("FAIL fill_valid_r step %0d got %b exp %b", i, valid1, (i > 0)); end
      if (i > 0) begin
        checks++; if (z1 !== 4'(i)) begin errors++; $display("FAIL fill_z_r step %0d got %h exp %h", i, z1, 4'(i)); end
      end
    end
    checks++; if (q0 !== 4'h1) begin errors++; $display("FAIL fill_q got %h exp 1", q0); end
    checks++; if (q2 !== 4'h3) begin errors++; $display("FAIL fill_q6 got %h exp 3", q2); end
  endtask

  task automatic test_tap_sweep();
    e = 1'b0;
    for (int k = 0; k < 8; k++) begin
      addr = 3'(k);
      #2;
      checks++; if (z0 !== 4'(8 - k)) begin errors++; $display("FAIL sweep_z addr %0d got %h exp %h", k, z0, 4'(8 - k)); end
      checks++; if (z2 !== 4'((k >= 6) ? 3 : 8 - k)) begin errors++; $display("FAIL sweep_clamp addr %0d got %h", k, z2); end
      checks++; if (valid2 !== 1'b1) begin errors++; $display("FAIL sweep_valid6 addr %0d got %b exp 1", k, valid2); end
      tick();
      #2;
      checks++; if (z1 !== 4'(8 - k)) begin errors++; $display("FAIL sweep_z_r addr %0d got %h exp %h", k, z1, 4'(8 - k)); end
    end
    // Saturation: one more shift leaves fill at DEPTH.
    a = 4'h9; e = 1'b1; addr = 3'd0;
    tick();
    e = 1'b0;
    #2;
    checks++; if (fill0 !== 4'd8) begin errors++; $display("FAIL hold_fill got %0d exp 8", fill0); end
    checks++; if (z0 !== 4'h9) begin errors++; $display("FAIL hold_z got %h exp 9", z0); end
    checks++; if (q0 !== 4'h2) begin errors++; $display("FAIL hold_q got %h exp 2", q0); end
    checks++; if (fill2 !== 4'd6) begin errors++; $display("FAIL hold_fill6 got %0d exp 6", fill2); end
  endtask

  task automatic test_valid_boundary();
    rst = 1'b1; model_reset();
    tick();
    rst = 1'b0;
    addr = 3'd2; e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 4'(4'h5 + i);
      tick();
      #2;
      checks++; if (valid0 !== (i == 2)) begin errors++; $display("FAIL vb_shift %0d got %b exp %b", i, valid0, (i == 2)); end
    end
    e = 1'b0; addr = 3'd3;
    #2;
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL vb_addr3 got %b exp 0", valid0); end
    checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL vb_addr3_d6 got %b exp 0", valid2); end
    tick();
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL vb_addr3_r got %b exp 0", valid1); end
    e = 1'b1; a = 4'hC;
    tick();
    e = 1'b0;
    #2;
    checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL vb_after_shift got %b exp 1", valid0); end
    checks++; if (z0 !== 4'h5) begin errors++; $display("FAIL vb_z got %h exp 5", z0); end
    tick();
    checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL vb_after_shift_r got %b exp 1", valid1); end
  endtask

  task automatic test_enable_gating();
    for (int i = 0; i < 24; i++) begin
      a = 4'($urandom); e = 1'($urandom); addr = 3'($urandom);
      #2;
      checks++; if (fill0 !== 4'(f8)) begin errors++; $display("FAIL gate_fill cyc %0d got %0d exp %0d", i, fill0, f8); end
      checks++; if (valid0 !== (int'(addr) < f8)) begin errors++; $display("FAIL gate_valid cyc %0d got %b", i, valid0); end
      if (int'(addr) < f8) begin
        checks++; if (z0 !== tap8(addr)) begin errors++; $display("FAIL gate_z cyc %0d got %h exp %h", i, z0, tap8(addr)); end
      end
      if (f8 == 8) begin
        checks++; if (q0 !== tap8(3'd7)) begin errors++; $display("FAIL gate_q cyc %0d got %h exp %h", i, q0, tap8(3'd7)); end
      end
      if (((addr >= 3'd6) ? 5 : int'(addr)) < f6) begin
        checks++; if (z2 !== tap6(addr)) begin errors++; $display("FAIL gate_z6 cyc %0d got %h exp %h", i, z2, tap6(addr)); end
      end
      checks++; if (valid1 !== vr1) begin errors++; $display("FAIL gate_valid_r cyc %0d got %b exp %b", i, valid1, vr1); end
      if (vr1) begin
        checks++; if (z1 !== zr1) begin errors++; $display("FAIL gate_z_r cyc %0d got %h exp %h", i, z1, zr1); end
      end
      tick();
    end
  endtask

  task automatic test_mid_reset_clamp();
    logic [3:0] seq [6];
    seq[0] = 4'hA; seq[1] = 4'h5; seq[2] = 4'hC; seq[3] = 4'h3; seq[4] = 4'h9; seq[5] = 4'h6;
    e = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 4'(i + 3);
      tick();
    end
    e = 1'b0; addr = 3'd7;
    rst = 1'b1; model_reset();
    #2;
    checks++; if (fill2 !== 4'd0) begin errors++; $display("FAIL mid_fill6 got %0d exp 0", fill2); end
    checks++; if (fill0 !== 4'd0) begin errors++; $display("FAIL mid_fill8 got %0d exp 0", fill0); end
    checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL mid_valid6 got %b exp 0", valid2); end
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL mid_valid_r got %b exp 0", valid1); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = seq[i]; e = 1'b1;
      tick();
      #2;
      checks++; if (valid2 !== (i == 5)) begin errors++; $display("FAIL clamp_valid shift %0d got %b exp %b", i, valid2, (i == 5)); end
      checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL clamp_valid8 shift %0d got %b exp 0", i, valid0); end
    end
    e = 1'b0;
    #2;
    checks++; if (z2 !== 4'hA) begin errors++; $display("FAIL clamp_z got %h exp a", z2); end
    checks++; if (q2 !== 4'hA) begin errors++; $display("FAIL clamp_q got %h exp a", q2); end
    // Reset and enable together: no increment may be counted.
    e = 1'b1; a = 4'hF; rst = 1'b1; model_reset();
    tick();
    rst = 1'b0; e = 1'b0;
    #2;
    checks++; if (fill2 !== 4'd0) begin errors++; $display("FAIL rst_e_fill6 got %0d exp 0", fill2); end
    checks++; if (fill0 !== 4'd0) begin errors++; $display("FAIL rst_e_fill8 got %0d exp 0", fill0); end
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL rst_e_valid got %b exp 0", valid0); end
  endtask

  initial begin
    for (int ch = 0; ch < 4; ch++) begin
      m8[ch] = '0;
      m6[ch] = '0;
    end
    model_reset();
    #1;
    test_reset();
    test_fill();
    test_tap_sweep();
    test_valid_boundary();
    test_enable_gating();
    test_mid_reset_clamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
